lt24_frame_sequencer: RTL and testbench



---
 rtl/lt24_frame_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_lt24_frame_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lt24_frame_sequencer.sv
// -----------------------------------------------------------------------------
// lt24_frame_sequencer
//
// Purpose:
//   Walks one full-screen raster (x fastest, then y) for the LT24Display pixel
//   interface. For each pixel the sequencer:
//   - issues the image-ROM read address, including window offset and
//     horizontal pixel doubling;
//   - waits out the one-cycle synchronous ROM latency;
//   - presents the colour with pixelWrite until the display takes it with
//     pixelReady.
//   Pixels outside the image window get BACK_COLOR.
//   A scan is started by start, can chain frames through continuous, and can
//   be cut short by abort.
//
// Ports:
//   clock       in   system clock
//   reset       in   synchronous, active-high; clears all state and outputs
//   start       in   begin a frame when idle (ignored while busy)
//   continuous  in   sampled at frame end; 1 = restart the scan immediately
//   abort       in   return to idle at once, no frameDone
//   busy        out  high while a scan is in progress
//   frameDone   out  one-cycle pulse after the last pixel is accepted
//   frameCount  out  completed frames, wraps 255->0
//   romAddr     out  image ROM address
//   romData     in   ROM q, valid one cycle after romAddr
//   xAddr       out  pixel column of the current write
//   yAddr       out  pixel row of the current write
//   pixelData   out  pixel colour of the current write
//   pixelWrite  out  pixel valid towards the display
//   pixelReady  in   display accepts the pixel this cycle when pixelWrite=1
// -----------------------------------------------------------------------------
module lt24_frame_sequencer #(
  parameter int          WIDTH      = 240,
  parameter int          HEIGHT     = 320,
  parameter int          WIN_X      = 60,
  parameter int          WIN_Y      = 0,
  parameter int          WIN_W      = 120,
  parameter int          WIN_H      = 320,
  parameter int          X_SHIFT    = 1,
  parameter logic [15:0] BACK_COLOR = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        continuous,
  input  logic        abort,
  output logic        busy,
  output logic        frameDone,
  output logic [7:0]  frameCount,
  output logic [15:0] romAddr,
  input  logic [15:0] romData,
  output logic [7:0]  xAddr,
  output logic [8:0]  yAddr,
  output logic [15:0] pixelData,
  output logic        pixelWrite,
  input  logic        pixelReady
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;

  localparam logic [7:0]  X_LAST    = 8'(WIDTH - 1);
  localparam logic [8:0]  Y_LAST    = 9'(HEIGHT - 1);
  localparam logic [9:0]  WX_LO     = 10'(WIN_X);
  localparam logic [9:0]  WY_LO     = 10'(WIN_Y);
  localparam logic [9:0]  WX_SPAN   = 10'(WIN_W);
  localparam logic [9:0]  WY_SPAN   = 10'(WIN_H);
  localparam logic [16:0] ROW_PITCH = 17'(WIN_W >> X_SHIFT);

  state_t     state, state_nxt;
  logic [7:0] x_cnt, x_nxt;
  logic [8:0] y_cnt, y_nxt;

  // Window membership. Coordinates are widened to 10 bits and offset by the
  // window origin; a coordinate left of/above the origin wraps to a large
  // value, so one unsigned compare per axis covers both window edges.
  function automatic logic in_window(input logic [7:0] x, input logic [8:0] y);
    logic [9:0] dx;
    logic [9:0] dy;
    dx = {2'b00, x} - WX_LO;
    dy = {1'b0, y} - WY_LO;
    return (dx < WX_SPAN) && (dy < WY_SPAN);
  endfunction

  // ROM address for a display pixel: row offset times stored row length plus
  // the scaled column offset, formed at 17 bits and truncated to 16.
  function automatic logic [15:0] rom_index(input logic [7:0] x, input logic [8:0] y);
    logic [16:0] dx;
    logic [16:0] dy;
    dx = {9'd0, x} - 17'(WIN_X);
    dy = {8'd0, y} - 17'(WIN_Y);
    if (!in_window(x, y)) begin
      return 16'h0000;
    end
    return 16'(dy * ROW_PITCH + (dx >> X_SHIFT));
  endfunction

  // Next-state and counter-advance logic; abort overrides every state.
  always_comb begin
    state_nxt = state;
    x_nxt     = x_cnt;
    y_nxt     = y_cnt;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt = S_FETCH;
            x_nxt     = 8'd0;
            y_nxt     = 9'd0;
          end
        end
        S_FETCH:   state_nxt = S_WAIT;
        S_WAIT:    state_nxt = S_PRESENT;
        S_PRESENT: begin
          if (pixelReady) begin
            if (x_cnt < X_LAST) begin
              x_nxt     = x_cnt + 8'd1;
              state_nxt = S_FETCH;
            end else if (y_cnt < Y_LAST) begin
              x_nxt     = 8'd0;
              y_nxt     = y_cnt + 9'd1;
              state_nxt = S_FETCH;
            end else begin
              state_nxt = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (continuous) begin
            state_nxt = S_FETCH;
            x_nxt     = 8'd0;
            y_nxt     = 9'd0;
          end else begin
            state_nxt = S_IDLE;
          end
        end
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      x_cnt      <= 8'd0;
      y_cnt      <= 9'd0;
      busy       <= 1'b0;
      frameDone  <= 1'b0;
      frameCount <= 8'd0;
      romAddr    <= 16'h0000;
      xAddr      <= 8'd0;
      yAddr      <= 9'd0;
      pixelData  <= 16'h0000;
      pixelWrite <= 1'b0;
    end else begin
      state      <= state_nxt;
      x_cnt      <= x_nxt;
      y_cnt      <= y_nxt;
      busy       <= (state_nxt != S_IDLE);
      pixelWrite <= (state_nxt == S_PRESENT);
      frameDone  <= (state_nxt == S_DONE);
      if (state_nxt == S_DONE) begin
        frameCount <= frameCount + 8'd1;
      end
      // Address goes out on entry to FETCH so the ROM samples it at the
      // FETCH->WAIT edge and its q is valid while in WAIT.
      if (state_nxt == S_FETCH) begin
        romAddr <= rom_index(x_nxt, y_nxt);
      end
      // Pixel coordinates and colour change only here, while pixelWrite=0.
      if (state == S_WAIT && state_nxt == S_PRESENT) begin
        xAddr     <= x_cnt;
        yAddr     <= y_cnt;
        pixelData <= in_window(x_cnt, y_cnt) ? romData : BACK_COLOR;
      end
    end
  end

endmodule

// File: tb/tb_lt24_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lt24_frame_sequencer
//
// Three sequencer instances share one clock:
//   dut_a  default 240x320 geometry, ROM q = address
//   dut_b  12x6 screen with a small window, hashed ROM contents, random
//          backpressure
//   dut_c  4x2 screen, continuous scanning and frame counter wrap
// Expected pixels come from the window/address rules evaluated with plain
// integer arithmetic per (x,y).
// -----------------------------------------------------------------------------
module tb_lt24_frame_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A : default geometry ----------------
  logic        reset_a, start_a, cont_a, abort_a, rdy_a;
  logic        busy_a, done_a, pw_a;
  logic [7:0]  fc_a, x_a;
  logic [8:0]  y_a;
  logic [15:0] ra_a, rd_a, pd_a;

  lt24_frame_sequencer dut_a (
    .clock(clock), .reset(reset_a), .start(start_a), .continuous(cont_a),
    .abort(abort_a), .busy(busy_a), .frameDone(done_a), .frameCount(fc_a),
    .romAddr(ra_a), .romData(rd_a), .xAddr(x_a), .yAddr(y_a),
    .pixelData(pd_a), .pixelWrite(pw_a), .pixelReady(rdy_a)
  );

  always_ff @(posedge clock) rd_a <= ra_a;

  // ---------------- instance B : small window, random ready ----------------
  logic        reset_b, start_b, cont_b, abort_b, rdy_b;
  logic        busy_b, done_b, pw_b;
  logic [7:0]  fc_b, x_b;
  logic [8:0]  y_b;
  logic [15:0] ra_b, rd_b, pd_b;
  logic [15:0] salt_b;

  lt24_frame_sequencer #(
    .WIDTH(12), .HEIGHT(6), .WIN_X(2), .WIN_Y(1), .WIN_W(8), .WIN_H(3),
    .X_SHIFT(1), .BACK_COLOR(16'hABCD)
  ) dut_b (
    .clock(clock), .reset(reset_b), .start(start_b), .continuous(cont_b),
    .abort(abort_b), .busy(busy_b), .frameDone(done_b), .frameCount(fc_b),
    .romAddr(ra_b), .romData(rd_b), .xAddr(x_b), .yAddr(y_b),
    .pixelData(pd_b), .pixelWrite(pw_b), .pixelReady(rdy_b)
  );

  function automatic logic [15:0] rom_b(input logic [15:0] a);
    logic [15:0] p;
    p = a * 16'h9E37;
    return p ^ salt_b;
  endfunction

  always_ff @(posedge clock) rd_b <= rom_b(ra_b);

  // ---------------- instance C : 4x2, continuous ----------------
  logic        reset_c, start_c, cont_c, abort_c, rdy_c;
  logic        busy_c, done_c, pw_c;
  logic [7:0]  fc_c, x_c;
  logic [8:0]  y_c;
  logic [15:0] ra_c, rd_c, pd_c;

  lt24_frame_sequencer #(.WIDTH(4), .HEIGHT(2)) dut_c (
    .clock(clock), .reset(reset_c), .start(start_c), .continuous(cont_c),
    .abort(abort_c), .busy(busy_c), .frameDone(done_c), .frameCount(fc_c),
    .romAddr(ra_c), .romData(rd_c), .xAddr(x_c), .yAddr(y_c),
    .pixelData(pd_c), .pixelWrite(pw_c), .pixelReady(rdy_c)
  );

  always_ff @(posedge clock) rd_c <= ra_c;

  // Handshake / frameDone counters seen at the active edge.
  int hs_b = 0, dn_b = 0, hs_c = 0;
  always @(posedge clock) begin
    if (pw_b && rdy_b) hs_b <= hs_b + 1;
    if (done_b)        dn_b <= dn_b + 1;
    if (pw_c && rdy_c) hs_c <= hs_c + 1;
  end

  // ---------------- reference model ----------------
  // ROM address of a display pixel, or -1 when outside the window.
  function automatic int win_addr(input int x, input int y, input int wx, input int wy,
                                  input int ww, input int wh, input int xs);
    if (x >= wx && x < wx + ww && y >= wy && y < wy + wh)
      return ((y - wy) * (ww >> xs) + ((x - wx) >> xs)) % 65536;
    return -1;
  endfunction

  function automatic logic [15:0] exp_a(input int x, input int y);
    int a;
    a = win_addr(x, y, 60, 0, 120, 320, 1);
    return (a < 0) ? 16'h0000 : 16'(a);
  endfunction

  function automatic logic [15:0] exp_b(input int x, input int y);
    int a;
    a = win_addr(x, y, 2, 1, 8, 3, 1);
    return (a < 0) ? 16'hABCD : rom_b(16'(a));
  endfunction

  // Spot values for the default geometry with ROM q = address.
  int spot_x[6] = '{60, 61, 62, 179, 180, 60};
  int spot_y[6] = '{ 0,  0,  0,   0,   0,  1};
  int spot_v[6] = '{ 0,  0,  1,  59,   0, 60};

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_pw_a(input string tag);
    int n = 0;
    while (pw_a !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    chk(tag, 32'(pw_a), 1);
  endtask

  task automatic wait_pw_b(input string tag);
    int n = 0;
    while (pw_b !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    chk(tag, 32'(pw_b), 1);
  endtask

  // ---------------- directed sequence ----------------
  int px, py, n, hold, prev_hs;

  initial begin
    reset_a = 1'b1; start_a = 1'b0; cont_a = 1'b0; abort_a = 1'b0; rdy_a = 1'b1;
    reset_b = 1'b1; start_b = 1'b0; cont_b = 1'b0; abort_b = 1'b0; rdy_b = 1'b0;
    reset_c = 1'b1; start_c = 1'b0; cont_c = 1'b0; abort_c = 1'b0; rdy_c = 1'b1;
    salt_b  = 16'($urandom);
    step();
    step();

    // ---- A: reset values ----
    chk("a_rst_busy", 32'(busy_a), 0);
    chk("a_rst_pw",   32'(pw_a),   0);
    chk("a_rst_done", 32'(done_a), 0);
    chk("a_rst_fc",   32'(fc_a),   0);
    chk("a_rst_ra",   32'(ra_a),   0);
    chk("a_rst_x",    32'(x_a),    0);
    chk("a_rst_y",    32'(y_a),    0);
    chk("a_rst_pd",   32'(pd_a),   0);
    reset_a = 1'b0;
    step();

    // ---- A: start latency ----
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("a_busy_start", 32'(busy_a), 1);
    chk("a_lat1_pw",    32'(pw_a),   0);
    step();
    chk("a_lat2_pw",    32'(pw_a),   0);
    step();
    chk("a_lat3_pw",    32'(pw_a),   1);
    chk("a_first_x",    32'(x_a),    0);
    chk("a_first_y",    32'(y_a),    0);
    chk("a_first_pd",   32'(pd_a),   0);

    // ---- A: scan to (4,7), window spots, backpressure at (10,3) ----
    for (int p = 0; p < 1685; p++) begin
      px = p % 240;
      py = p / 240;
      if (px == 10 && py == 3) rdy_a = 1'b0;
      wait_pw_a("a_pw");
      chk("a_x",   32'(x_a),  px);
      chk("a_y",   32'(y_a),  py);
      chk("a_pix", 32'(pd_a), 32'(exp_a(px, py)));
      for (int s = 0; s < 6; s++)
        if (px == spot_x[s] && py == spot_y[s]) chk("a_spot", 32'(pd_a), spot_v[s]);
      if (px == 10 && py == 3) begin
        for (int k = 0; k < 5; k++) begin
          step();
          chk("a_bp_pw", 32'(pw_a), 1);
          chk("a_bp_x",  32'(x_a),  10);
          chk("a_bp_y",  32'(y_a),  3);
          chk("a_bp_pd", 32'(pd_a), 32'(exp_a(10, 3)));
        end
        rdy_a = 1'b1;
      end
      step();
    end

    // ---- A: abort while presenting (5,7) ----
    rdy_a = 1'b0;
    wait_pw_a("a_ab_pw");
    chk("a_ab_x", 32'(x_a), 5);
    chk("a_ab_y", 32'(y_a), 7);
    abort_a = 1'b1;
    rdy_a   = 1'b1;
    step();
    abort_a = 1'b0;
    chk("a_ab_pw0",   32'(pw_a),   0);
    chk("a_ab_busy0", 32'(busy_a), 0);
    chk("a_ab_done0", 32'(done_a), 0);
    chk("a_ab_fc",    32'(fc_a),   0);
    step();
    chk("a_ab_done1", 32'(done_a), 0);

    // ---- A: abort and start together in idle ----
    abort_a = 1'b1;
    start_a = 1'b1;
    step();
    abort_a = 1'b0;
    start_a = 1'b0;
    chk("a_abst_busy", 32'(busy_a), 0);
    step();
    step();
    chk("a_abst_pw",   32'(pw_a),   0);

    // ---- A: restart scans from (0,0) ----
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("a_re_busy", 32'(busy_a), 1);
    step();
    step();
    chk("a_re_pw", 32'(pw_a), 1);
    chk("a_re_x",  32'(x_a),  0);
    chk("a_re_y",  32'(y_a),  0);
    for (int p = 0; p < 62; p++) begin
      wait_pw_a("a_re_pwl");
      chk("a_re_xl", 32'(x_a), p);
      step();
    end

    // ---- A: synchronous reset mid-handshake at (62,0) ----
    rdy_a = 1'b0;
    wait_pw_a("a_mr_pw");
    chk("a_mr_x",  32'(x_a),  62);
    chk("a_mr_pd", 32'(pd_a), 1);
    chk("a_mr_ra", 32'(ra_a), 1);
    reset_a = 1'b1;
    start_a = 1'b1;
    step();
    chk("a_mr_pw0",   32'(pw_a),   0);
    chk("a_mr_busy0", 32'(busy_a), 0);
    chk("a_mr_done0", 32'(done_a), 0);
    chk("a_mr_fc0",   32'(fc_a),   0);
    chk("a_mr_ra0",   32'(ra_a),   0);
    chk("a_mr_x0",    32'(x_a),    0);
    chk("a_mr_y0",    32'(y_a),    0);
    chk("a_mr_pd0",   32'(pd_a),   0);
    step();
    reset_a = 1'b0;
    start_a = 1'b0;
    rdy_a   = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("a_mr_busy_idle", 32'(busy_a), 0);
    chk("a_mr_pw_idle",   32'(pw_a),   0);

    // ---- B: full frame with random backpressure ----
    chk("b_rst_busy", 32'(busy_b), 0);
    chk("b_rst_pw",   32'(pw_b),   0);
    chk("b_rst_fc",   32'(fc_b),   0);
    reset_b = 1'b0;
    step();
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("b_busy_start", 32'(busy_b), 1);
    step();
    step();
    chk("b_lat3_pw", 32'(pw_b), 1);
    for (int p = 0; p < 72; p++) begin
      px = p % 12;
      py = p / 12;
      wait_pw_b("b_pw");
      chk("b_x",   32'(x_b),  px);
      chk("b_y",   32'(y_b),  py);
      chk("b_pix", 32'(pd_b), 32'(exp_b(px, py)));
      hold = int'($urandom_range(0, 3));
      for (int k = 0; k < hold; k++) begin
        step();
        chk("b_bp_pw",  32'(pw_b), 1);
        chk("b_bp_x",   32'(x_b),  px);
        chk("b_bp_pix", 32'(pd_b), 32'(exp_b(px, py)));
      end
      rdy_b = 1'b1;
      step();
      rdy_b = 1'b0;
      if (p != 71) chk("b_no_done", 32'(done_b), 0);
    end
    chk("b_done",      32'(done_b), 1);
    chk("b_fc",        32'(fc_b),   1);
    chk("b_done_busy", 32'(busy_b), 1);
    step();
    chk("b_done_end", 32'(done_b), 0);
    chk("b_idle",     32'(busy_b), 0);
    chk("b_idle_pw",  32'(pw_b),   0);
    step();
    step();
    chk("b_hs_total",   hs_b, 72);
    chk("b_done_total", dn_b, 1);

    // ---- C: continuous frames and counter wrap ----
    chk("c_rst_x",    32'(x_c),    0);
    chk("c_rst_y",    32'(y_c),    0);
    chk("c_rst_pd",   32'(pd_c),   0);
    chk("c_rst_busy", 32'(busy_c), 0);
    reset_c = 1'b0;
    cont_c  = 1'b1;
    step();
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    prev_hs = 0;
    for (int f = 1; f <= 256; f++) begin
      n = 0;
      while (done_c !== 1'b1 && n < 40) begin
        step();
        n++;
      end
      chk("c_done", 32'(done_c), 1);
      chk("c_hs_per_frame", hs_c - prev_hs, 8);
      chk("c_count", 32'(fc_c), f % 256);
      prev_hs = hs_c;
      step();
    end
    chk("c_wrap", 32'(fc_c), 0);
    chk("c_busy_cont", 32'(busy_c), 1);
    cont_c = 1'b0;
    n = 0;
    while (done_c !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("c_last_done", 32'(done_c), 1);
    chk("c_last_hs",   hs_c - prev_hs, 8);
    chk("c_last_fc",   32'(fc_c), 1);
    step();
    chk("c_stop_busy", 32'(busy_c), 0);
    step();
    step();
    step();
    chk("c_stop_pw",    32'(pw_c),   0);
    chk("c_stop_busy2", 32'(busy_c), 0);
    reset_c = 1'b1;
    step();
    chk("c_rst_fc", 32'(fc_c), 0);
    reset_c = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
